// File: rtl/accel_host_sequencer_if.sv
// Valid/ready stream bundle used for the host input and output streams.
interface accel_host_sequencer_if #(
  parameter int W = 64
) ();
  logic         valid;
  logic         ready;
  logic [W-1:0] data;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/accel_host_sequencer.sv
// Host-side sequencer for one accelerator tile: configure, load bias, weights
// and ifmap from the input stream, kick the operation, then stream the ofmap
// buffer out through a single output register.
module accel_host_sequencer #(
  parameter int WD = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [9:0]             n_wght,
  input  logic [9:0]             n_ifmap,
  input  logic [9:0]             n_ofmap,
  accel_host_sequencer_if.slave  src,
  accel_host_sequencer_if.master dst,
  output logic                   config_load,
  output logic                   config_done,
  output logic                   bias_write,
  output logic                   wght_ready,
  output logic                   ifmap_ready,
  output logic                   op_go,
  output logic                   op_done,
  output logic                   wght_en,
  output logic                   ifmap_en,
  output logic                   ofmap_en,
  output logic [7:0]             wght_wen,
  output logic [7:0]             ifmap_wen,
  output logic [9:0]             wght_addrin,
  output logic [9:0]             ifmap_addrin,
  output logic [9:0]             ofmap_addrin,
  output logic [8*WD-1:0]        wght_din,
  output logic [8*WD-1:0]        ifmap_din,
  input  logic                   dataload_ready,
  input  logic                   tile_done,
  input  logic [8*WD-1:0]        ofmap_dout,
  output logic                   busy
);

  typedef enum logic [3:0] {
    IDLE, CFG, BIAS, WGHT, IFMAP, GO, WAIT, READ, FIN
  } state_t;

  state_t            state_q, state_d;
  logic [9:0]        n_wght_q, n_wght_d;
  logic [9:0]        n_ifmap_q, n_ifmap_d;
  logic [9:0]        n_ofmap_q, n_ofmap_d;
  logic [9:0]        cnt_q, cnt_d;        // source-phase write address
  logic [9:0]        iss_q, iss_d;        // ofmap reads issued
  logic [9:0]        acc_q, acc_d;        // ofmap words accepted on dst
  logic              cfg_step_q, cfg_step_d;
  logic              rd_pend_q, rd_pend_d;
  logic              dst_valid_q, dst_valid_d;
  logic [8*WD-1:0]   dst_data_q, dst_data_d;
  logic              op_go_q, op_go_d;

  logic              src_rdy;
  logic              src_hs;
  logic              rd_issue;
  logic              dst_acc;

  // State register and all datapath flops.
  // NOTE: every sequential assignment is non-blocking so all flops update
  // together from the values present before the edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      n_wght_q    <= '0;
      n_ifmap_q   <= '0;
      n_ofmap_q   <= '0;
      cnt_q       <= '0;
      iss_q       <= '0;
      acc_q       <= '0;
      cfg_step_q  <= 1'b0;
      rd_pend_q   <= 1'b0;
      dst_valid_q <= 1'b0;
      dst_data_q  <= '0;
      op_go_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      n_wght_q    <= n_wght_d;
      n_ifmap_q   <= n_ifmap_d;
      n_ofmap_q   <= n_ofmap_d;
      cnt_q       <= cnt_d;
      iss_q       <= iss_d;
      acc_q       <= acc_d;
      cfg_step_q  <= cfg_step_d;
      rd_pend_q   <= rd_pend_d;
      dst_valid_q <= dst_valid_d;
      dst_data_q  <= dst_data_d;
      op_go_q     <= op_go_d;
    end
  end

  // Next-state logic for the tile sequence.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = CFG;
      CFG:     if (cfg_step_q) state_d = BIAS;
      BIAS:    if (src_hs && cnt_q == 10'd1) state_d = WGHT;
      WGHT:    if (cnt_q == n_wght_q) state_d = IFMAP;
      IFMAP:   if (cnt_q == n_ifmap_q) state_d = GO;
      GO:      if (dataload_ready) state_d = WAIT;
      WAIT:    if (tile_done) state_d = (n_ofmap_q == 10'd0) ? FIN : READ;
      READ:    if (dst_acc && acc_q == n_ofmap_q - 10'd1) state_d = FIN;
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Control strobes and buffer ports, decoded from state and handshakes.
  // NOTE: each output gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    src_rdy      = 1'b0;
    config_load  = 1'b0;
    config_done  = 1'b0;
    bias_write   = 1'b0;
    wght_ready   = 1'b0;
    ifmap_ready  = 1'b0;
    op_done      = 1'b0;
    unique case (state_q)
      CFG:     begin config_load = ~cfg_step_q; config_done = cfg_step_q; end
      BIAS:    begin src_rdy = 1'b1; bias_write = 1'b1; end
      WGHT:    if (cnt_q == n_wght_q) wght_ready = 1'b1; else src_rdy = 1'b1;
      IFMAP:   if (cnt_q == n_ifmap_q) ifmap_ready = 1'b1; else src_rdy = 1'b1;
      FIN:     op_done = 1'b1;
      default: ;
    endcase

    src_hs   = src.valid & src_rdy;
    dst_acc  = dst_valid_q & dst.ready;
    // One read in flight at most, and only into an empty or draining register.
    rd_issue = (state_q == READ) && (iss_q != n_ofmap_q) && !rd_pend_q &&
               (!dst_valid_q || dst.ready);

    wght_en      = src_hs && (state_q == BIAS || state_q == WGHT);
    wght_wen     = wght_en ? 8'hFF : 8'h00;
    wght_addrin  = wght_en ? cnt_q : 10'd0;
    wght_din     = wght_en ? src.data : '0;
    ifmap_en     = src_hs && (state_q == IFMAP);
    ifmap_wen    = ifmap_en ? 8'hFF : 8'h00;
    ifmap_addrin = ifmap_en ? cnt_q : 10'd0;
    ifmap_din    = ifmap_en ? src.data : '0;
    ofmap_en     = rd_issue;
    ofmap_addrin = rd_issue ? iss_q : 10'd0;
  end

  // Counters, sampled word counts and the output register.
  always_comb begin
    n_wght_d    = n_wght_q;
    n_ifmap_d   = n_ifmap_q;
    n_ofmap_d   = n_ofmap_q;
    cnt_d       = cnt_q;
    iss_d       = iss_q;
    acc_d       = acc_q;
    dst_valid_d = dst_valid_q;
    dst_data_d  = dst_data_q;
    cfg_step_d  = (state_q == CFG) ? ~cfg_step_q : 1'b0;
    op_go_d     = (state_q == GO) && dataload_ready;
    rd_pend_d   = rd_issue;

    if (state_q == IDLE && start) begin
      n_wght_d  = n_wght;
      n_ifmap_d = n_ifmap;
      n_ofmap_d = n_ofmap;
    end

    // Counters restart on every phase change; never wrap inside a phase.
    if (state_d != state_q) begin
      cnt_d = '0;
      iss_d = '0;
      acc_d = '0;
    end else begin
      if (src_hs)   cnt_d = cnt_q + 10'd1;
      if (rd_issue) iss_d = iss_q + 10'd1;
      if (dst_acc)  acc_d = acc_q + 10'd1;
    end

    // Read data lands exactly one cycle after the issue.
    if (rd_pend_q) begin
      dst_valid_d = 1'b1;
      dst_data_d  = ofmap_dout;
    end else if (dst_acc) begin
      dst_valid_d = 1'b0;
    end
  end

  assign src.ready = src_rdy;
  assign dst.valid = dst_valid_q;
  assign dst.data  = dst_data_q;
  assign op_go     = op_go_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_accel_host_sequencer.sv
// Directed bench for accel_host_sequencer with a one-cycle-latency ofmap model.
module tb_accel_host_sequencer;
  localparam int WD = 8;
  localparam int DW = 8 * WD;

  logic clk = 1'b0;
  logic rst;
  logic start;
  logic [9:0] n_wght, n_ifmap, n_ofmap;
  logic config_load, config_done, bias_write, wght_ready, ifmap_ready;
  logic op_go, op_done, wght_en, ifmap_en, ofmap_en, busy;
  logic [7:0] wght_wen, ifmap_wen;
  logic [9:0] wght_addrin, ifmap_addrin, ofmap_addrin;
  logic [DW-1:0] wght_din, ifmap_din;
  logic dataload_ready, tile_done;
  logic [DW-1:0] ofmap_dout = '0;

  accel_host_sequencer_if #(.W(DW)) src_if ();
  accel_host_sequencer_if #(.W(DW)) dst_if ();

  always #5 clk = ~clk;

  accel_host_sequencer #(.WD(WD)) dut (
    .clk(clk), .rst(rst), .start(start),
    .n_wght(n_wght), .n_ifmap(n_ifmap), .n_ofmap(n_ofmap),
    .src(src_if.slave), .dst(dst_if.master),
    .config_load(config_load), .config_done(config_done),
    .bias_write(bias_write), .wght_ready(wght_ready),
    .ifmap_ready(ifmap_ready), .op_go(op_go), .op_done(op_done),
    .wght_en(wght_en), .ifmap_en(ifmap_en), .ofmap_en(ofmap_en),
    .wght_wen(wght_wen), .ifmap_wen(ifmap_wen),
    .wght_addrin(wght_addrin), .ifmap_addrin(ifmap_addrin),
    .ofmap_addrin(ofmap_addrin), .wght_din(wght_din), .ifmap_din(ifmap_din),
    .dataload_ready(dataload_ready), .tile_done(tile_done),
    .ofmap_dout(ofmap_dout), .busy(busy)
  );

  // Ofmap buffer model: read data is a tagged address, one cycle after en.
  always @(posedge clk) if (ofmap_en) ofmap_dout <= 64'hA5A5_0000_0000_0000 | 64'(ofmap_addrin);

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Observations collected by run_seq.
  int n_cfg_load, n_cfg_done, n_wr_ready, n_if_ready, n_op_go, n_op_done;
  int n_ofmap_en, n_bad_wr, n_unstable, n_bad_wen;
  int c_last_bias, c_wght_ready, c_dl_rise, c_op_go, c_tile, c_op_done;
  bit timed_out;
  logic [63:0] bias_d[$], wght_d[$], ifmap_d[$], dst_d[$];
  int bias_a[$], wght_a[$], ifmap_a[$];

  task automatic run_seq(input int nw, input int ni, input int no, input bit gap,
                         input int dl_delay, input bit stall_pat, input int rst_after);
    bit pat[7] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    int idx = 0, ifr_c = -1, vcyc = 0;
    bit prev_stall = 1'b0;
    logic [63:0] prev_data = '0;
    bit finished = 1'b0;
    n_cfg_load = 0; n_cfg_done = 0; n_wr_ready = 0; n_if_ready = 0;
    n_op_go = 0; n_op_done = 0; n_ofmap_en = 0; n_bad_wr = 0; n_unstable = 0; n_bad_wen = 0;
    c_last_bias = -1; c_wght_ready = -1; c_dl_rise = -1; c_op_go = -1; c_tile = -1; c_op_done = -1;
    timed_out = 1'b0;
    bias_d.delete(); wght_d.delete(); ifmap_d.delete(); dst_d.delete();
    bias_a.delete(); wght_a.delete(); ifmap_a.delete();
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if (rst_after > 0 && dst_d.size() >= rst_after) begin
        rst = 1'b1;
        finished = 1'b1;
        break;
      end
      // Drive this cycle's inputs; a second start while busy must be ignored.
      start   = (c == 0) || (c == 6);
      n_wght  = (c == 0) ? 10'(nw) : 10'h3FF;
      n_ifmap = (c == 0) ? 10'(ni) : 10'h3FF;
      n_ofmap = (c == 0) ? 10'(no) : 10'h3FF;
      src_if.valid   = gap ? (c % 2 == 0) : 1'b1;
      src_if.data    = 64'h100 + 64'(idx);
      dataload_ready = (ifr_c >= 0) && (c - ifr_c > dl_delay);
      tile_done      = (c_op_go >= 0) && (c == c_op_go + 3);
      dst_if.ready   = (dst_if.valid && stall_pat && vcyc < 7) ? pat[vcyc] : 1'b1;
      #1;
      if (config_load) n_cfg_load++;
      if (config_done) n_cfg_done++;
      if (wght_en) begin
        if (wght_wen != 8'hFF) n_bad_wen++;
        if (bias_write) begin
          bias_d.push_back(wght_din); bias_a.push_back(int'(wght_addrin)); c_last_bias = c;
        end else begin
          wght_d.push_back(wght_din); wght_a.push_back(int'(wght_addrin));
        end
      end
      if (ifmap_en) begin
        if (ifmap_wen != 8'hFF) n_bad_wen++;
        ifmap_d.push_back(ifmap_din); ifmap_a.push_back(int'(ifmap_addrin));
      end
      if ((wght_en || ifmap_en) && !src_if.valid) n_bad_wr++;
      if (wght_ready) begin n_wr_ready++; c_wght_ready = c; end
      if (ifmap_ready) begin n_if_ready++; ifr_c = c; end
      if (dataload_ready && c_dl_rise < 0) c_dl_rise = c;
      if (op_go) begin n_op_go++; if (c_op_go < 0) c_op_go = c; end
      if (tile_done) c_tile = c;
      if (ofmap_en) n_ofmap_en++;
      if (prev_stall && (!dst_if.valid || dst_if.data !== prev_data)) n_unstable++;
      if (dst_if.valid) begin
        vcyc++;
        if (dst_if.ready) dst_d.push_back(dst_if.data);
      end
      prev_stall = dst_if.valid && !dst_if.ready;
      prev_data  = dst_if.data;
      if (src_if.valid && src_if.ready) idx++;
      if (op_done) begin
        n_op_done++; c_op_done = c; finished = 1'b1;
        break;
      end
    end
    if (!finished) timed_out = 1'b1;
    if (!rst) begin
      @(negedge clk);
      start = 1'b0; src_if.valid = 1'b0; dataload_ready = 1'b0; tile_done = 1'b0;
      dst_if.ready = 1'b1;
      #1;
      if (op_done) n_op_done++;
    end
  endtask

  initial begin
    int spurious;
    rst = 1'b1; start = 1'b0; n_wght = '0; n_ifmap = '0; n_ofmap = '0;
    src_if.valid = 1'b0; src_if.data = '0; dst_if.ready = 1'b0;
    dataload_ready = 1'b0; tile_done = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_src_ready", src_if.ready, 0);
    check("rst_dst_valid", dst_if.valid, 0);
    check("rst_dst_data", dst_if.data, 0);
    rst = 1'b0;

    // Basic sequence with a start pulse while busy.
    run_seq(3, 2, 2, 1'b0, 0, 1'b0, 0);
    check("t1_timeout", timed_out, 0);
    check("t1_cfg_load", n_cfg_load, 1);
    check("t1_cfg_done", n_cfg_done, 1);
    check("t1_bias_cnt", bias_d.size(), 2);
    check("t1_bias_a1", bias_a[1], 1);
    check("t1_bias_d0", bias_d[0], 64'h100);
    check("t1_bias_d1", bias_d[1], 64'h101);
    check("t1_wght_cnt", wght_d.size(), 3);
    check("t1_wght_a2", wght_a[2], 2);
    check("t1_wght_d0", wght_d[0], 64'h102);
    check("t1_wght_d2", wght_d[2], 64'h104);
    check("t1_ifmap_cnt", ifmap_d.size(), 2);
    check("t1_ifmap_a1", ifmap_a[1], 1);
    check("t1_ifmap_d0", ifmap_d[0], 64'h105);
    check("t1_wen", n_bad_wen, 0);
    check("t1_wght_ready", n_wr_ready, 1);
    check("t1_ifmap_ready", n_if_ready, 1);
    check("t1_op_go", n_op_go, 1);
    check("t1_op_done", n_op_done, 1);
    check("t1_ofmap_en", n_ofmap_en, 2);
    check("t1_dst_cnt", dst_d.size(), 2);
    check("t1_dst0", dst_d[0], 64'hA5A5_0000_0000_0000);
    check("t1_dst1", dst_d[1], 64'hA5A5_0000_0000_0001);
    check("t1_idle", busy, 0);

    // Source gaps: writes only on valid cycles, contiguous addresses.
    run_seq(4, 1, 1, 1'b1, 0, 1'b0, 0);
    check("t2_timeout", timed_out, 0);
    check("t2_bad_wr", n_bad_wr, 0);
    check("t2_wght_cnt", wght_d.size(), 4);
    check("t2_wght_a0", wght_a[0], 0);
    check("t2_wght_a3", wght_a[3], 3);
    check("t2_wght_d3", wght_d[3], 64'h105);
    check("t2_ifmap_d0", ifmap_d[0], 64'h106);

    // dataload_ready late: op_go in the cycle after it rises.
    run_seq(1, 1, 1, 1'b0, 10, 1'b0, 0);
    check("t3_timeout", timed_out, 0);
    check("t3_op_go_cnt", n_op_go, 1);
    check("t3_op_go_cycle", c_op_go - c_dl_rise, 1);
    check("t3_dl_delay", c_dl_rise - c_wght_ready, 13);

    // Output back-pressure.
    run_seq(2, 2, 4, 1'b0, 0, 1'b1, 0);
    check("t4_timeout", timed_out, 0);
    check("t4_dst_cnt", dst_d.size(), 4);
    check("t4_dst0", dst_d[0], 64'hA5A5_0000_0000_0000);
    check("t4_dst1", dst_d[1], 64'hA5A5_0000_0000_0001);
    check("t4_dst2", dst_d[2], 64'hA5A5_0000_0000_0002);
    check("t4_dst3", dst_d[3], 64'hA5A5_0000_0000_0003);
    check("t4_stable", n_unstable, 0);
    check("t4_ofmap_en", n_ofmap_en, 4);

    // Reset mid-READ after two words.
    run_seq(1, 1, 4, 1'b0, 0, 1'b0, 2);
    #1;
    check("t5_busy", busy, 0);
    check("t5_dst_valid", dst_if.valid, 0);
    check("t5_dst_data", dst_if.data, 0);
    check("t5_strobes", {ofmap_en, wght_en, ifmap_en, op_go, op_done, src_if.ready}, 0);
    start = 1'b0; src_if.valid = 1'b0; dataload_ready = 1'b0; tile_done = 1'b0;
    dst_if.ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    spurious = 0;
    repeat (6) begin
      @(negedge clk);
      if (dst_if.valid || busy) spurious++;
    end
    check("t5_no_valid_after", spurious, 0);
    run_seq(3, 2, 2, 1'b0, 0, 1'b0, 0);
    check("t5_rerun_timeout", timed_out, 0);
    check("t5_rerun_dst_cnt", dst_d.size(), 2);
    check("t5_rerun_dst0", dst_d[0], 64'hA5A5_0000_0000_0000);
    check("t5_rerun_dst1", dst_d[1], 64'hA5A5_0000_0000_0001);
    check("t5_rerun_done", n_op_done, 1);

    // Empty weight and ofmap phases.
    run_seq(0, 1, 0, 1'b0, 0, 1'b0, 0);
    check("t6_timeout", timed_out, 0);
    check("t6_wght_cnt", wght_d.size(), 0);
    check("t6_wght_ready", n_wr_ready, 1);
    check("t6_wght_ready_cycle", c_wght_ready - c_last_bias, 1);
    check("t6_fin_after_tile", c_op_done - c_tile, 1);
    check("t6_ofmap_en", n_ofmap_en, 0);
    check("t6_dst_cnt", dst_d.size(), 0);
    check("t6_op_done", n_op_done, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/accel_host_sequencer.md
ACCEL_HOST_SEQUENCER -- requirements
Module: accel_host_sequencer

Interface
REQ-001 Parameter WD, default 8: accelerator pixel width; data words are 8*WD bits.
REQ-002 clk  in  1: single clock; all logic rising-edge.
REQ-003 rst  in  1: asynchronous, active-high reset.
REQ-004 start  in  1: one-cycle pulse; begins a tile sequence, ignored unless IDLE.
REQ-005 n_wght, n_ifmap, n_ofmap  in  10 each: word counts; value 0 means skip that phase.
REQ-006 src_valid in 1, src_ready out 1, src_data in 8*WD: input stream, ordered 2 bias words, then n_wght weight words, then n_ifmap ifmap words.
REQ-007 dst_valid out 1, dst_ready in 1, dst_data out 8*WD: ofmap output stream.
REQ-008 config_load, config_done, bias_write, wght_ready, ifmap_ready, op_go, op_done  out  1 each: accelerator control strobes.
REQ-009 wght_en, ifmap_en, ofmap_en  out  1; wght_wen, ifmap_wen  out  8; wght_addrin, ifmap_addrin, ofmap_addrin  out  10; wght_din, ifmap_din  out  8*WD: accelerator buffer ports.
REQ-010 dataload_ready, tile_done  in  1; ofmap_dout  in  8*WD: accelerator status and read data.
REQ-011 busy  out  1: high in every state except IDLE.

Function
REQ-012 States: IDLE, CFG, BIAS, WGHT, IFMAP, GO, WAIT, READ, FIN.
REQ-013 IDLE->CFG on start; CFG drives config_load=1 one cycle, then config_done=1 one cycle, then ->BIAS.
REQ-014 BIAS: bias_write=1 throughout; each src handshake (src_valid&src_ready) writes src_data via wght_en=1, wght_wen=8'hFF, wght_addrin=0 then 1; after 2nd word ->WGHT.
REQ-015 WGHT: each handshake writes wght port at address 0,1,..,n_wght-1; after last word pulse wght_ready one cycle, ->IFMAP; n_wght=0 pulses wght_ready immediately.
REQ-016 IFMAP: same rule on ifmap port, addresses 0..n_ifmap-1; after last word pulse ifmap_ready one cycle, ->GO.
REQ-017 src_ready=1 only in BIAS/WGHT/IFMAP; wen/en driven only in the handshake cycle, 0 otherwise; a src_valid gap produces no write and holds the address counter.
REQ-018 GO: wait for dataload_ready=1, then op_go=1 exactly one cycle, ->WAIT.
REQ-019 WAIT: on tile_done=1 ->READ; n_ofmap=0 goes directly to FIN.
REQ-020 READ: ofmap_en=1 with ofmap_addrin=k issues read k; ofmap_dout valid exactly 1 cycle later and is registered into dst_data with dst_valid=1.
REQ-021 At most one read outstanding; a new address issues only when output register empty or drained this cycle (dst_valid&dst_ready); ordered, no loss, no duplication under any dst_ready pattern.
REQ-022 dst_data/dst_valid held stable while dst_valid=1 and dst_ready=0.
REQ-023 After word n_ofmap-1 is accepted on dst, ->FIN; FIN pulses op_done one cycle, ->IDLE.
REQ-024 Address counters 10 bits, reset to 0 on phase entry; count 1023 never wraps within a phase (max count 1023 words).
REQ-025 start while busy ignored; counts sampled at start and stable for the sequence.

Reset
REQ-026 rst asserted at any time: state IDLE, all counters 0, every output 0 (dst_data 0), within the same cycle, no further strobes.
REQ-027 Reset mid-READ discards in-flight read data; no dst_valid after reset release until a new sequence reaches READ.

Verification
REQ-028 n_wght=3,n_ifmap=2,n_ofmap=2, src always valid, dst always ready -> bias at 0,1 with bias_write; wght addr 0,1,2; wght_ready, ifmap_ready, op_go, op_done each exactly one cycle; dst emits ofmap_dout of addr 0 then 1.
REQ-029 src_valid toggling 1,0,1,0 in WGHT -> writes only on valid cycles, addresses contiguous 0..n_wght-1.
REQ-030 dataload_ready held 0 for 10 cycles in GO -> op_go not asserted until cycle after it rises.
REQ-031 n_ofmap=4, dst_ready pattern 0,0,1,0,1,1,1 -> dst words addr 0..3 in order, data stable during stalls.
REQ-032 rst pulsed mid-READ after 2 of 4 words -> all outputs 0 immediately; new start runs full sequence correctly.
REQ-033 n_wght=0, n_ofmap=0 -> wght_ready pulses on WGHT entry, FIN follows tile_done, no ofmap_en ever.
